// File: rtl/lbp_host_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : lbp_host_mem_if
// Description : Bundles the load stream, engine gray-read / LBP-write port,
//               both external SRAM ports, the result stream and status.
//               slave = the host responder, master = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface lbp_host_mem_if;
  // Load stream
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  // Engine gray-read port
  logic        gray_req;
  logic [13:0] gray_addr;
  logic        gray_ready;
  logic [7:0]  gray_data;
  // Engine LBP-write port
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  // Gray SRAM
  logic [13:0] gsram_addr;
  logic        gsram_we;
  logic [7:0]  gsram_wdata;
  logic [7:0]  gsram_rdata;
  // LBP SRAM
  logic [13:0] lsram_addr;
  logic        lsram_we;
  logic [7:0]  lsram_wdata;
  logic [7:0]  lsram_rdata;
  // Result stream
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  // Status
  logic [14:0] lbp_cnt;
  logic        err;
  logic        done;

  modport slave (
    input  in_valid, in_data, gray_req, gray_addr, lbp_valid, lbp_addr,
           lbp_data, finish, gsram_rdata, lsram_rdata, out_ready,
    output in_ready, gray_ready, gray_data, gsram_addr, gsram_we,
           gsram_wdata, lsram_addr, lsram_we, lsram_wdata, out_valid,
           out_data, lbp_cnt, err, done
  );

  modport master (
    output in_valid, in_data, gray_req, gray_addr, lbp_valid, lbp_addr,
           lbp_data, finish, gsram_rdata, lsram_rdata, out_ready,
    input  in_ready, gray_ready, gray_data, gsram_addr, gsram_we,
           gsram_wdata, lsram_addr, lsram_we, lsram_wdata, out_valid,
           out_data, lbp_cnt, err, done
  );
endinterface
`default_nettype wire

// File: rtl/lbp_host_mem.sv
`default_nettype none
// ============================================================================
// Module      : lbp_host_mem
// Description : Host-side responder for the LBP engine. Loads a 128x128 gray
//               image into the gray SRAM (pre-clearing the LBP SRAM), serves
//               engine reads with 1-cycle latency, passes LBP writes through
//               to the LBP SRAM, then streams the LBP image out.
// Revision    : 1.0 - initial release
// ============================================================================
module lbp_host_mem #(
  parameter int NPIX = 16384,
  parameter int NINT = 15876
) (
  input logic           clk,
  input logic           reset,
  lbp_host_mem_if.slave bus
);

  localparam logic [13:0] LAST_PIX = 14'(NPIX - 1);
  localparam logic [14:0] NPIX_CNT = 15'(NPIX);
  localparam logic [14:0] LAST_POP = 15'(NPIX - 1);
  localparam logic [15:0] NINT_CNT = 16'(NINT);
  localparam logic [14:0] CNT_SAT  = 15'h7fff;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_q,    state_d;
  logic [13:0] ld_ptr_q,   ld_ptr_d;
  logic        rd_pend_q,  rd_pend_d;
  logic [7:0]  hold_q,     hold_d;
  logic [14:0] lbp_cnt_q,  lbp_cnt_d;
  logic        err_q,      err_d;
  logic [14:0] rd_ptr_q,   rd_ptr_d;
  logic        infl_q,     infl_d;
  logic [7:0]  fifo0_q,    fifo0_d;
  logic [7:0]  fifo1_q,    fifo1_d;
  logic        fifo_wp_q,  fifo_wp_d;
  logic        fifo_rp_q,  fifo_rp_d;
  logic [1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [14:0] pop_cnt_q,  pop_cnt_d;

  logic        in_ready;
  logic        gray_ready;
  logic [13:0] gsram_addr;
  logic        gsram_we;
  logic [7:0]  gsram_wdata;
  logic [13:0] lsram_addr;
  logic        lsram_we;
  logic [7:0]  lsram_wdata;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        done;
  logic        fifo_push;
  logic        fifo_pop;
  logic [2:0]  occ;

  // State register; reset aborts any phase and returns to LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_LOAD;
    else       state_q <= state_d;
  end

  // Datapath registers: pointers, read-hold, counters, output FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_ptr_q   <= '0;
      rd_pend_q  <= 1'b0;
      hold_q     <= '0;
      lbp_cnt_q  <= '0;
      err_q      <= 1'b0;
      rd_ptr_q   <= '0;
      infl_q     <= 1'b0;
      fifo0_q    <= '0;
      fifo1_q    <= '0;
      fifo_wp_q  <= 1'b0;
      fifo_rp_q  <= 1'b0;
      fifo_cnt_q <= '0;
      pop_cnt_q  <= '0;
    end else begin
      ld_ptr_q   <= ld_ptr_d;
      rd_pend_q  <= rd_pend_d;
      hold_q     <= hold_d;
      lbp_cnt_q  <= lbp_cnt_d;
      err_q      <= err_d;
      rd_ptr_q   <= rd_ptr_d;
      infl_q     <= infl_d;
      fifo0_q    <= fifo0_d;
      fifo1_q    <= fifo1_d;
      fifo_wp_q  <= fifo_wp_d;
      fifo_rp_q  <= fifo_rp_d;
      fifo_cnt_q <= fifo_cnt_d;
      pop_cnt_q  <= pop_cnt_d;
    end
  end

  // Next-state and output decode for all four phases.
  always_comb begin
    state_d     = state_q;
    ld_ptr_d    = ld_ptr_q;
    rd_pend_d   = 1'b0;
    hold_d      = hold_q;
    lbp_cnt_d   = lbp_cnt_q;
    err_d       = err_q;
    rd_ptr_d    = rd_ptr_q;
    infl_d      = 1'b0;
    fifo0_d     = fifo0_q;
    fifo1_d     = fifo1_q;
    fifo_wp_d   = fifo_wp_q;
    fifo_rp_d   = fifo_rp_q;
    fifo_cnt_d  = fifo_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    in_ready    = 1'b0;
    gray_ready  = 1'b0;
    gsram_addr  = '0;
    gsram_we    = 1'b0;
    gsram_wdata = '0;
    lsram_addr  = '0;
    lsram_we    = 1'b0;
    lsram_wdata = '0;
    out_valid   = 1'b0;
    out_data    = '0;
    done        = 1'b0;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    occ         = '0;

    // The SRAM returns the previous cycle's read now; keep it for later holds.
    if (rd_pend_q) hold_d = bus.gsram_rdata;

    case (state_q)
      ST_LOAD: begin
        in_ready    = 1'b1;
        gsram_addr  = ld_ptr_q;
        gsram_wdata = bus.in_data;
        lsram_addr  = ld_ptr_q;
        if (bus.in_valid) begin
          // LBP SRAM is zeroed alongside so borders read back as 0.
          gsram_we = 1'b1;
          lsram_we = 1'b1;
          ld_ptr_d = ld_ptr_q + 14'd1;
          if (ld_ptr_q == LAST_PIX) state_d = ST_SERVE;
        end
      end

      ST_SERVE: begin
        gray_ready = 1'b1;
        if (bus.gray_req) begin
          gsram_addr = bus.gray_addr;
          rd_pend_d  = 1'b1;
        end
        if (bus.lbp_valid) begin
          lsram_we    = 1'b1;
          lsram_addr  = bus.lbp_addr;
          lsram_wdata = bus.lbp_data;
          if (lbp_cnt_q != CNT_SAT) lbp_cnt_d = lbp_cnt_q + 15'd1;
        end
        if (bus.finish) begin
          // Count includes a write landing in the finish cycle itself.
          state_d = ST_DRAIN;
          err_d   = err_q |
                    (({1'b0, lbp_cnt_q} + {15'd0, bus.lbp_valid}) != NINT_CNT);
        end
      end

      ST_DRAIN: begin
        out_valid = (fifo_cnt_q != 2'd0);
        out_data  = fifo_rp_q ? fifo1_q : fifo0_q;
        fifo_pop  = out_valid & bus.out_ready;
        fifo_push = infl_q;
        // Occupancy counts the slot freed by this cycle's pop so the 2-entry
        // FIFO sustains one byte per cycle.
        occ = {1'b0, fifo_cnt_q} + {2'b00, infl_q} - {2'b00, fifo_pop};
        if ((occ < 3'd2) && (rd_ptr_q < NPIX_CNT)) begin
          lsram_addr = rd_ptr_q[13:0];
          rd_ptr_d   = rd_ptr_q + 15'd1;
          infl_d     = 1'b1;
        end
        if (fifo_push) begin
          if (fifo_wp_q) fifo1_d = bus.lsram_rdata;
          else           fifo0_d = bus.lsram_rdata;
          fifo_wp_d = ~fifo_wp_q;
        end
        if (fifo_pop) begin
          fifo_rp_d = ~fifo_rp_q;
          pop_cnt_d = pop_cnt_q + 15'd1;
          if (pop_cnt_q == LAST_POP) state_d = ST_DONE;
        end
        fifo_cnt_d = fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
      end

      ST_DONE: begin
        done = 1'b1;
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  assign bus.in_ready    = in_ready;
  assign bus.gray_ready  = gray_ready;
  assign bus.gray_data   = rd_pend_q ? bus.gsram_rdata : hold_q;
  assign bus.gsram_addr  = gsram_addr;
  assign bus.gsram_we    = gsram_we;
  assign bus.gsram_wdata = gsram_wdata;
  assign bus.lsram_addr  = lsram_addr;
  assign bus.lsram_we    = lsram_we;
  assign bus.lsram_wdata = lsram_wdata;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = out_data;
  assign bus.lbp_cnt     = lbp_cnt_q;
  assign bus.err         = err_q;
  assign bus.done        = done;

endmodule
`default_nettype wire

// File: tb/tb_lbp_host_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lbp_host_mem
// Description : Self-checking bench for lbp_host_mem with behavioural SRAMs,
//               a behavioural LBP engine and an image-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lbp_host_mem;

  localparam int NPIX = 16384;
  localparam int NINT = 15876;

  logic clk = 1'b0;
  logic reset;

  lbp_host_mem_if bus ();

  lbp_host_mem #(.NPIX(NPIX), .NINT(NINT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // External synchronous-read SRAMs, pre-filled with junk.
  logic [7:0] gmem [NPIX] = '{default: 8'hA5};
  logic [7:0] lmem [NPIX] = '{default: 8'hA5};

  // Gray and LBP SRAM behaviour: write plus registered read.
  always @(posedge clk) begin
    if (bus.gsram_we) gmem[bus.gsram_addr] <= bus.gsram_wdata;
    bus.gsram_rdata <= gmem[bus.gsram_addr];
    if (bus.lsram_we) lmem[bus.lsram_addr] <= bus.lsram_wdata;
    bus.lsram_rdata <= lmem[bus.lsram_addr];
  end

  // Reference model state
  logic [7:0] exp_gray [NPIX];
  logic [7:0] exp_lbp  [NPIX];
  logic [7:0] exp_gd;
  logic       exp_err;
  int         n_tests;
  int         n_fail;

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.gray_req  = 1'b0;
    bus.gray_addr = '0;
    bus.lbp_valid = 1'b0;
    bus.lbp_addr  = '0;
    bus.lbp_data  = '0;
    bus.finish    = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  // LBP code: bit k set when neighbour k (clockwise from top-left) >= centre.
  function automatic logic [7:0] lbp_of(input int r, input int c);
    logic [7:0] ctr;
    logic [7:0] res;
    int rr, cc;
    ctr = exp_gray[r*128 + c];
    res = 8'd0;
    for (int k = 0; k < 8; k++) begin
      case (k)
        0:       begin rr = r - 1; cc = c - 1; end
        1:       begin rr = r - 1; cc = c;     end
        2:       begin rr = r - 1; cc = c + 1; end
        3:       begin rr = r;     cc = c + 1; end
        4:       begin rr = r + 1; cc = c + 1; end
        5:       begin rr = r + 1; cc = c;     end
        6:       begin rr = r + 1; cc = c - 1; end
        default: begin rr = r;     cc = c - 1; end
      endcase
      res[k] = (exp_gray[rr*128 + cc] >= ctr);
    end
    return res;
  endfunction

  // Assert reset (checked while held), release, check the idle LOAD state.
  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.gray_ready !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: in_ready=%b gray_ready=%b done=%b, required 1/0/0",
               bus.in_ready, bus.gray_ready, bus.done);
    end
    n_tests++;
    if (bus.gray_data !== 8'h00 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: gray_data=%h out_valid=%b out_data=%h, required 00/0/00",
               bus.gray_data, bus.out_valid, bus.out_data);
    end
    n_tests++;
    if (bus.lbp_cnt !== 15'd0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: lbp_cnt=%0d err=%b, required 0/0", bus.lbp_cnt, bus.err);
    end
    n_tests++;
    if (bus.gsram_we !== 1'b0 || bus.lsram_we !== 1'b0 ||
        bus.gsram_addr !== 14'd0 || bus.lsram_addr !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_sram: gwe=%b lwe=%b gaddr=%0d laddr=%0d, required 0/0/0/0",
               bus.gsram_we, bus.lsram_we, bus.gsram_addr, bus.lsram_addr);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.gray_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b gray_ready=%b out_valid=%b, required 1/0/0",
               bus.in_ready, bus.gray_ready, bus.out_valid);
    end
    @(posedge clk);
    #1;
    exp_gd = 8'h00;
  endtask

  // Load an image (ramp or random), optionally with random in_valid gaps.
  task automatic test_load(input bit ramp, input bit gaps);
    int i = 0;
    int cyc = 0;
    int mism;
    for (int k = 0; k < NPIX; k++) begin
      exp_gray[k] = ramp ? k[7:0] : 8'($urandom);
      exp_lbp[k]  = 8'h00;
    end
    while (i < NPIX && cyc < 3*NPIX) begin
      bus.in_valid = gaps ? ($urandom_range(15) != 0) : 1'b1;
      bus.in_data  = exp_gray[i];
      @(negedge clk);
      n_tests++;
      if (bus.gray_ready !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL load_ready beat %0d: gray_ready=%b in_ready=%b, required 0/1",
                 i, bus.gray_ready, bus.in_ready);
      end
      n_tests++;
      if (bus.gsram_we !== bus.in_valid || bus.lsram_we !== bus.in_valid ||
          bus.gsram_addr !== i[13:0] || bus.lsram_addr !== i[13:0] ||
          bus.lsram_wdata !== 8'h00) begin
        n_fail++;
        $display("FAIL load_write beat %0d: gwe=%b lwe=%b gaddr=%0d laddr=%0d lwd=%h, required %b/%b/%0d/%0d/00",
                 i, bus.gsram_we, bus.lsram_we, bus.gsram_addr, bus.lsram_addr,
                 bus.lsram_wdata, bus.in_valid, bus.in_valid, i, i);
      end
      @(posedge clk);
      #1;
      if (bus.in_valid) i++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    n_tests++;
    if (i != NPIX) begin
      n_fail++;
      $display("FAIL load_timeout: got %0d beats, required %0d", i, NPIX);
    end
    @(negedge clk);
    n_tests++;
    if (bus.gray_ready !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_to_serve: gray_ready=%b in_ready=%b, required 1/0",
               bus.gray_ready, bus.in_ready);
    end
    mism = 0;
    for (int k = 0; k < NPIX; k++) if (gmem[k] !== exp_gray[k]) mism++;
    n_tests++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL load_gsram: %0d bytes differ, required 0", mism);
    end
    mism = 0;
    for (int k = 0; k < NPIX; k++) if (lmem[k] !== 8'h00) mism++;
    n_tests++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL load_lsram_clear: %0d bytes nonzero, required 0", mism);
    end
    @(posedge clk);
    #1;
  endtask

  // Reads of 129, 0, 16383 back to back, then three idle cycles.
  task automatic test_ramp_reads();
    logic [13:0] addrs [3] = '{14'd129, 14'd0, 14'd16383};
    logic [7:0]  seq   [7] = '{8'h00, 8'h81, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int j = 0; j < 7; j++) begin
      bus.gray_req  = (j < 3);
      bus.gray_addr = (j < 3) ? addrs[j] : 14'd0;
      @(negedge clk);
      n_tests++;
      if (bus.gray_data !== seq[j]) begin
        n_fail++;
        $display("FAIL ramp_read cycle %0d: gray_data=%h, required %h", j, bus.gray_data, seq[j]);
      end
      if (j < 3) begin
        n_tests++;
        if (bus.gsram_addr !== addrs[j]) begin
          n_fail++;
          $display("FAIL ramp_addr cycle %0d: gsram_addr=%0d, required %0d",
                   j, bus.gsram_addr, addrs[j]);
        end
      end
      @(posedge clk);
      #1;
    end
    drive_idle();
    exp_gd = exp_gray[16383];
  endtask

  // Engine phase: LBP writes (full interior or 100 random) with random reads.
  task automatic test_serve(input bit full);
    logic [13:0] wa [$];
    logic [7:0]  wd [$];
    int total, sent, cyc, mism;
    bit v, fin, req;
    logic [13:0] ra;
    if (full) begin
      for (int r = 1; r < 127; r++)
        for (int c = 1; c < 127; c++) begin
          wa.push_back(14'(r*128 + c));
          wd.push_back(lbp_of(r, c));
        end
    end else begin
      for (int k = 0; k < 100; k++) begin
        wa.push_back(14'($urandom));
        wd.push_back(8'($urandom));
      end
      wa[60] = wa[20];
    end
    total = wa.size();
    for (int k = 0; k < total; k++) exp_lbp[wa[k]] = wd[k];
    exp_err = (total != NINT);
    sent = 0;
    cyc  = 0;
    fin  = 1'b0;
    while (!fin && cyc < 40000) begin
      v   = (sent < total) && ($urandom_range(15) != 0);
      fin = full ? (v && sent == total - 1) : (sent == total);
      req = 1'($urandom_range(1));
      ra  = 14'($urandom);
      bus.gray_req  = req;
      bus.gray_addr = ra;
      bus.lbp_valid = v;
      bus.finish    = fin;
      bus.in_valid  = 1'($urandom_range(1));
      if (sent < total) begin
        bus.lbp_addr = wa[sent];
        bus.lbp_data = wd[sent];
      end
      @(negedge clk);
      n_tests++;
      if (bus.gray_data !== exp_gd) begin
        n_fail++;
        $display("FAIL serve_gray_data cycle %0d: got %h, required %h", cyc, bus.gray_data, exp_gd);
      end
      n_tests++;
      if (bus.lbp_cnt !== 15'(sent)) begin
        n_fail++;
        $display("FAIL serve_lbp_cnt cycle %0d: got %0d, required %0d", cyc, bus.lbp_cnt, sent);
      end
      n_tests++;
      if (bus.lsram_we !== v || bus.gsram_we !== 1'b0 || bus.gray_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL serve_strobes cycle %0d: lwe=%b gwe=%b gray_ready=%b, required %b/0/1",
                 cyc, bus.lsram_we, bus.gsram_we, bus.gray_ready, v);
      end
      if (v) begin
        n_tests++;
        if (bus.lsram_addr !== wa[sent] || bus.lsram_wdata !== wd[sent]) begin
          n_fail++;
          $display("FAIL serve_write cycle %0d: addr=%0d data=%h, required %0d/%h",
                   cyc, bus.lsram_addr, bus.lsram_wdata, wa[sent], wd[sent]);
        end
      end
      if (req) begin
        n_tests++;
        if (bus.gsram_addr !== ra) begin
          n_fail++;
          $display("FAIL serve_read_addr cycle %0d: got %0d, required %0d", cyc, bus.gsram_addr, ra);
        end
      end
      @(posedge clk);
      #1;
      if (req) exp_gd = exp_gray[ra];
      if (v) sent++;
      cyc++;
    end
    drive_idle();
    n_tests++;
    if (!fin) begin
      n_fail++;
      $display("FAIL serve_timeout: %0d of %0d writes sent", sent, total);
    end
    @(negedge clk);
    n_tests++;
    if (bus.lbp_cnt !== 15'(total) || bus.err !== exp_err) begin
      n_fail++;
      $display("FAIL finish_status: lbp_cnt=%0d err=%b, required %0d/%b",
               bus.lbp_cnt, bus.err, total, exp_err);
    end
    n_tests++;
    if (bus.gray_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.gray_data !== exp_gd) begin
      n_fail++;
      $display("FAIL drain_entry: gray_ready=%b out_valid=%b gray_data=%h, required 0/0/%h",
               bus.gray_ready, bus.out_valid, bus.gray_data, exp_gd);
    end
    mism = 0;
    for (int k = 0; k < NPIX; k++) if (lmem[k] !== exp_lbp[k]) mism++;
    n_tests++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL lsram_contents: %0d bytes differ, required 0", mism);
    end
    @(posedge clk);
    #1;
  endtask

  // Drain starting one cycle after DRAIN entry. mode 0: out_ready held high;
  // mode 1: out_ready pattern 1,0,0,1. Stops after stop_at pops.
  task automatic test_drain(input int mode, input int stop_at);
    int k = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [7:0] held = 8'h00;
    while (k < stop_at && cyc < 40000) begin
      bus.out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      @(negedge clk);
      if (mode == 0) begin
        n_tests++;
        if (bus.out_valid !== (cyc >= 1)) begin
          n_fail++;
          $display("FAIL drain_rate cycle %0d: out_valid=%b, required %b", cyc, bus.out_valid, (cyc >= 1));
        end
      end
      if (stalled) begin
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
          n_fail++;
          $display("FAIL drain_stall cycle %0d: valid=%b data=%h, required 1/%h",
                   cyc, bus.out_valid, bus.out_data, held);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        n_tests++;
        if (bus.out_data !== exp_lbp[k]) begin
          n_fail++;
          $display("FAIL drain_data byte %0d: got %h, required %h", k, bus.out_data, exp_lbp[k]);
        end
        k++;
      end
      n_tests++;
      if (bus.done !== 1'b0 || bus.err !== exp_err) begin
        n_fail++;
        $display("FAIL drain_status cycle %0d: done=%b err=%b, required 0/%b",
                 cyc, bus.done, bus.err, exp_err);
      end
      stalled = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
      held    = bus.out_data;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.out_ready = 1'b0;
    n_tests++;
    if (k != stop_at) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d bytes, required %0d", k, stop_at);
    end
    if (stop_at == NPIX) begin
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        n_tests++;
        if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.err !== exp_err) begin
          n_fail++;
          $display("FAIL done_state cycle +%0d: done=%b out_valid=%b err=%b, required 1/0/%b",
                   j + 1, bus.done, bus.out_valid, bus.err, exp_err);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_gd  = 8'h00;
    exp_err = 1'b0;
    drive_idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_load(1'b1, 1'b1);
    test_ramp_reads();
    test_serve(1'b1);
    test_drain(0, 500);
    test_reset();
    test_load(1'b0, 1'b0);
    test_serve(1'b0);
    test_drain(1, NPIX);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lbp_host_mem.md
# lbp_host_mem

- Host-side responder for the LBP engine's gray-read / LBP-write interface.
- Loads a 128x128 8-bit gray image from a byte stream into an external gray SRAM.
- Serves the engine's gray read requests with 1-cycle latency and captures LBP result writes into an external LBP SRAM.
- After the engine asserts `finish`, streams the full 16384-byte LBP image out over a valid/ready port.

## Interface
Parameters:
- NPIX, 16384: pixel count (128x128); address width fixed at 14.
- NINT, 15876: expected LBP write count (126x126 interior).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  load-stream byte valid
- in_data  in  8  load-stream pixel, raster order
- in_ready  out  1  load-stream ready
- gray_req  in  1  engine read request
- gray_addr  in  14  engine read address
- gray_ready  out  1  image loaded, engine may start
- gray_data  out  8  read data
- lbp_valid  in  1  engine result write strobe
- lbp_addr  in  14  result address
- lbp_data  in  8  result value
- finish  in  1  engine done
- gsram_addr  out  14  gray SRAM address
- gsram_we  out  1  gray SRAM write enable
- gsram_wdata  out  8  gray SRAM write data
- gsram_rdata  in  8  gray SRAM read data, valid 1 cycle after address (synchronous read)
- lsram_addr  out  14  LBP SRAM address
- lsram_we  out  1  LBP SRAM write enable
- lsram_wdata  out  8  LBP SRAM write data
- lsram_rdata  in  8  LBP SRAM read data, 1-cycle latency
- out_valid  out  1  result stream valid
- out_data  out  8  result stream byte, raster order
- out_ready  in  1  result stream ready
- lbp_cnt  out  15  LBP writes accepted in SERVE
- err  out  1  sticky: `finish` seen with `lbp_cnt` != NINT
- done  out  1  all NPIX result bytes delivered

## Operation
- FSM states: LOAD, SERVE, DRAIN, DONE. Reset enters LOAD.
- **LOAD**
  - `in_ready` = 1.
  - Each handshake (`in_valid`&`in_ready`) writes `in_data` to gray SRAM and 0 to LBP SRAM at `ld_ptr`, then increments `ld_ptr`. This pre-clears the border pixels the engine never writes.
  - The handshake with `ld_ptr` = NPIX-1 moves the FSM to SERVE.
- **SERVE**
  - `gray_ready` = 1.
  - `gsram_addr` = `gray_addr` (combinational) whenever `gray_req` = 1. Each such cycle is a read.
  - `rd_pend` <= `gray_req`.
  - `gray_data` = `rd_pend` ? `gsram_rdata` : `hold`. `hold` captures `gsram_rdata` on the cycle after each read.
  - `lbp_valid` = 1 drives `lsram_we` = 1, `lsram_addr` = `lbp_addr`, `lsram_wdata` = `lbp_data` in the same cycle, and increments `lbp_cnt` (saturates at 32767).
  - A rewrite to the same address is written again and counted again.
  - `finish` = 1 moves the FSM to DRAIN. `err` <= (`lbp_cnt` + `lbp_valid`) != NINT, evaluated in that same cycle.
  - A `lbp_valid` asserted together with `finish` is still written.
- **DRAIN**
  - Reads the LBP SRAM at `rd_ptr` = 0..NPIX-1 into a 2-entry output FIFO.
  - A read issues when (FIFO occupancy + in-flight reads) < 2 and `rd_ptr` < NPIX.
  - Returned data is pushed to the FIFO 1 cycle after issue.
  - `out_valid` = FIFO non-empty; `out_data` = FIFO head. Pop on `out_valid`&`out_ready`.
  - The NPIX-th pop moves the FSM to DONE.
- **DONE**: `done` = 1. Terminal until reset.
- Inputs outside their state are ignored: `in_valid` outside LOAD, `gray_req`/`lbp_valid` outside SERVE, `finish` outside SERVE.
- `gsram_we` and `lsram_we` are 0 outside the states listed above.

## Timing
- Reset values: `in_ready` 1 (LOAD), all other outputs 0. `gray_data`, `hold`, `lbp_cnt`, pointers, FIFO and `err` are all cleared.
- Reset asserted mid-operation aborts any state immediately. SRAM contents are not cleared by reset; the next LOAD overwrites them.
- LOAD to SERVE: `gray_ready` rises the cycle after the last load handshake.
- Read latency: `gray_addr` presented with `gray_req` in cycle t; `gray_data` valid from the edge ending cycle t. It holds until the next read returns.
- Back-to-back reads sustain 1 per cycle.
- LBP write: 0-cycle pass-through. `lbp_cnt` updates at the edge ending the strobe cycle.
- DRAIN: first `out_valid` 2 cycles after entry. Throughput is 1 byte/cycle while `out_ready` = 1.
- Under backpressure, `out_data` is stable while `out_valid`&!`out_ready`. No byte is lost or duplicated.
- `done` rises the cycle after the final pop. `out_valid` is 0 in DONE.

## Test plan
- Load ramp `pix[i]` = i[7:0] for NPIX beats with random `in_valid` gaps -> `gray_ready` = 0 until 1 cycle after beat 16383. `gsram` holds the ramp; all `lsram` locations are 0.
- SERVE reads of addr 129, 0, 16383 on consecutive cycles, then `gray_req` low for 3 cycles -> `gray_data` = 0x81, 0x00, 0xFF on consecutive cycles, then holds 0xFF.
- Run the LBP engine on the ramp image -> `lbp_cnt` = 15876, `err` = 0 at `finish`. LBP SRAM matches the golden pattern; border bytes are 0.
- Assert `finish` after only 100 writes -> `err` = 1, sticky. DRAIN still outputs 16384 bytes.
- DRAIN with `out_ready` toggling 1,0,0,1 repeating -> exactly 16384 bytes in address order, each stable while stalled. `done` rises 1 cycle after the last pop.
- Assert reset mid-DRAIN at byte 500 -> all outputs return to reset values, `in_ready` = 1. A fresh load and serve completes correctly.
